// File: rtl/uint16_digit_splitter_pkg.sv
// Shared types and constants for the 16-bit binary to five-digit decimal splitter.
// The blanking helper turns a raw BCD word into the digit codes shown on the display.
package uint16_digit_splitter_pkg;

  localparam int WIDTH         = 16;
  localparam int UINT16_DIGITS = 5;
  localparam int BCD_W         = 4 * UINT16_DIGITS;

  typedef logic [3:0] digit_t;

  // Blank code chosen outside 0..9 so the segment decoders render it dark
  localparam digit_t EMPTY_DIGIT = 4'hF;

  localparam logic [3:0] SHIFT_LAST = 4'(WIDTH - 1);
  localparam logic [BCD_W-1:0] RESET_DIGITS = {{(UINT16_DIGITS-1){EMPTY_DIGIT}}, 4'd0};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  function automatic logic [BCD_W-1:0] blank_leading_zeros(input logic [BCD_W-1:0] bcd);
    logic             seen;
    logic [BCD_W-1:0] res;
    seen = 1'b0;
    res  = bcd;
    for (int i = UINT16_DIGITS - 1; i >= 1; i--) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        seen = 1'b1;
      end else begin
        seen = seen;
      end
      res[4*i +: 4] = seen ? bcd[4*i +: 4] : EMPTY_DIGIT;
    end
    return res;
  endfunction

endpackage

// File: rtl/uint16_digit_splitter_bcd_add3.sv
// Double-dabble correction for one BCD nibble: values of 5 or more get +3
// so the following left shift carries correctly into the next decade.
module bcd_add3_digit (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/uint16_digit_splitter.sv
// Sequential double-dabble conversion of a 16-bit value into five blanked decimal
// digits, one shift per clock, result committed atomically after the last shift.
module uint16_digit_splitter
  import uint16_digit_splitter_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     value,
  output logic [4:0][3:0] digit,
  output logic            busy,
  output logic            done
);

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [WIDTH-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] digit_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             done_q;

  logic [BCD_W-1:0] corr_s;
  logic [BCD_W-1:0] bcd_d;
  logic [WIDTH-1:0] bin_d;

  for (genvar g = 0; g < UINT16_DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit_i (bcd_q[4*g +: 4]),
      .digit_o (corr_s[4*g +: 4])
    );
  end

  // Correction uses pre-shift nibbles; the whole {bcd,bin} word then moves left by one
  always_comb begin
    {bcd_d, bin_d} = {corr_s, bin_q} << 1;
  end

  // Control FSM, shift datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      bin_q      <= '0;
      bcd_q      <= '0;
      digit_q    <= RESET_DIGITS;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            bin_q      <= value;
            bcd_q      <= '0;
            cnt_q      <= 4'd0;
            state_q    <= ST_SHIFT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_SHIFT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == SHIFT_LAST) begin
            state_q <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          digit_q    <= blank_leading_zeros(bcd_q);
          done_q     <= 1'b1;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign digit    = digit_q;

endmodule

// File: tb/tb_uint16_digit_splitter.sv
// Directed bench for uint16_digit_splitter; expected digit words are written
// as {digit4..digit0} hex with F as the blank code.
module tb_uint16_digit_splitter;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     value;
  logic [4:0][3:0] digit;
  logic            busy;
  logic            done;

  int total = 0;
  int bad   = 0;

  uint16_digit_splitter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .value    (value),
    .digit    (digit),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge with in_ready expected high; returns at the negedge after E17.
  task automatic convert(input logic [15:0] v, input logic [19:0] exp, input logic [19:0] prev,
                         input bit hold7, input string tag);
    value    = v;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (hold7) begin
      value    = 16'd7;
      in_valid = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    check({tag, " busy_after_accept"}, 20'(busy), 20'd1);
    check({tag, " ready_after_accept"}, 20'(in_ready), 20'd0);
    check({tag, " done_after_accept"}, 20'(done), 20'd0);
    repeat (16) @(negedge clk);
    in_valid = 1'b0;
    check({tag, " done_before_commit"}, 20'(done), 20'd0);
    check({tag, " digit_held"}, digit, prev);
    @(negedge clk);
    check({tag, " done_pulse"}, 20'(done), 20'd1);
    check({tag, " digit_result"}, digit, exp);
    check({tag, " ready_on_done"}, 20'(in_ready), 20'd1);
    check({tag, " busy_on_done"}, 20'(busy), 20'd0);
  endtask

  initial begin
    bit seen_done;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    value    = 16'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset digit", digit, 20'hFFFF0);
    check("reset ready", 20'(in_ready), 20'd1);
    check("reset busy", 20'(busy), 20'd0);
    check("reset done", 20'(done), 20'd0);

    convert(16'd0, 20'hFFFF0, 20'hFFFF0, 1'b0, "v0");
    @(negedge clk);
    check("v0 done_one_cycle", 20'(done), 20'd0);

    convert(16'd65535, 20'h65535, 20'hFFFF0, 1'b0, "v65535");
    @(negedge clk);

    convert(16'd1000, 20'hF1000, 20'h65535, 1'b1, "v1000_hold7");
    @(negedge clk);
    check("hold7 digit_kept", digit, 20'hF1000);
    check("hold7 busy_idle", 20'(busy), 20'd0);
    check("hold7 ready_idle", 20'(in_ready), 20'd1);

    convert(16'd42, 20'hFFF42, 20'hF1000, 1'b0, "v42");
    convert(16'd9, 20'hFFFF9, 20'hFFF42, 1'b0, "v9_b2b");
    @(negedge clk);
    check("v9 done_one_cycle", 20'(done), 20'd0);

    value    = 16'd12345;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("abort busy_before", 20'(busy), 20'd1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort digit", digit, 20'hFFFF0);
    check("abort ready", 20'(in_ready), 20'd1);
    check("abort busy", 20'(busy), 20'd0);
    check("abort done", 20'(done), 20'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("abort no_done", 20'(seen_done), 20'd0);
    check("abort digit_after", digit, 20'hFFFF0);

    convert(16'd12345, 20'h12345, 20'hFFFF0, 1'b0, "v12345");
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
